// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: Sysbus responder serving tagged critical-word-first bursts from an internal memory
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BURST_BEATS    = 8,
  parameter int MEM_WORDS      = 4096,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(BURST_BEATS);
  localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WDATA, WAIT, RESP} state_t;
  state_t                    r_state;
  logic                      r_reqack;
  logic                      r_respcyc;
  logic [BUS_DATA_WIDTH-1:0] r_resp;
  logic [BUS_TAG_WIDTH-1:0]  r_resptag;
  logic [BUS_TAG_WIDTH-1:0]  r_tag;
  logic [AW-1:0]             r_word;
  logic [BW-1:0]             r_beat;
  logic [LW-1:0]             r_lat;
  logic [BUS_DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic                      w_take;
  logic                      w_last;
  logic [BW-1:0]             w_beat_nx;
  logic [AW-1:0]             w_idx;
  logic [AW-1:0]             w_nidx;
  logic                      w_unused;
  // A beat is taken only while the FSM can consume request beats and no ack is pending
  assign w_take    = bus_reqcyc && !r_reqack && (r_state == IDLE || r_state == WDATA);
  assign w_last    = r_beat == BW'(BURST_BEATS - 1);
  assign w_beat_nx = r_beat + BW'(1);
  // Offset arithmetic wraps inside the line, giving critical-word-first order
  assign w_idx     = {r_word[AW-1:BW], r_word[BW-1:0] + r_beat};
  assign w_nidx    = {r_word[AW-1:BW], r_word[BW-1:0] + w_beat_nx};
  assign w_unused  = &{1'b0, bus_req[2:0], bus_req[BUS_DATA_WIDTH-1:3+AW]};
  assign bus_reqack  = r_reqack;
  assign bus_respcyc = r_respcyc;
  assign bus_resp    = r_resp;
  assign bus_resptag = r_resptag;
  // Memory array; contents survive reset, beats taken during reset are dropped
  always_ff @(posedge clk)
    if (w_take && r_state == WDATA && !reset) r_mem[w_idx] <= bus_req;
  // Request/response FSM with registered handshake outputs
  always_ff @(posedge clk)
    if (reset) begin
      r_state   <= IDLE;
      r_reqack  <= 1'b0;
      r_respcyc <= 1'b0;
      r_resp    <= '0;
      r_resptag <= '0;
      r_beat    <= '0;
      r_lat     <= '0;
    end else begin
      r_reqack <= w_take;
      case (r_state)
        IDLE: if (w_take) begin
          r_word  <= bus_req[3 +: AW];
          r_tag   <= bus_reqtag;
          r_beat  <= '0;
          r_lat   <= LW'(LATENCY - 1);
          r_state <= bus_reqtag[BUS_TAG_WIDTH-1] ? WDATA : WAIT;
        end
        WDATA: if (w_take) begin
          r_beat  <= w_beat_nx;
          r_state <= w_last ? IDLE : WDATA;
        end
        WAIT: if (r_lat == '0) begin
          r_state   <= RESP;
          r_respcyc <= 1'b1;
          r_resp    <= r_mem[w_idx];
          r_resptag <= r_tag;
        end else r_lat <= r_lat - LW'(1);
        RESP: if (bus_respack) begin
          if (w_last) begin
            r_state   <= IDLE;
            r_respcyc <= 1'b0;
          end else begin
            r_beat <= w_beat_nx;
            r_resp <= r_mem[w_nidx];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
